// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one read at a time on the instruction bus and
// presents the returned instruction to decode through a single-entry slot.
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] INST_NOP   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        jump_flag_i,
    input  logic        jtag_reset_flag_i,
    input  logic        hold_i,
    output logic        hold_pc_o,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        drop_q, drop_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_addr_q, inst_addr_d;

    logic flush;
    logic consume;
    logic slot_free;
    logic load;

    assign flush     = jump_flag_i | jtag_reset_flag_i;
    assign consume   = valid_q & ~hold_i;
    assign slot_free = ~valid_q | consume;

    // A grant of a request already marked for dropping must not move the PC.
    assign hold_pc_o = ~((state_q == S_REQ) & ibus_gnt_i & ~drop_q);

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        req_d       = req_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (slot_free && !flush) begin
                    addr_d  = {pc_i[31:2], 2'b00};
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (ibus_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_i) begin
                    load    = ~drop_q & ~flush;
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush wins over a same-cycle load so a stale instruction never reaches decode.
        if (flush) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
        end else if (load) begin
            valid_d     = 1'b1;
            inst_d      = ibus_rdata_i;
            inst_addr_d = addr_q;
        end else if (consume) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= RESET_ADDR;
            valid_q     <= 1'b0;
            inst_q      <= INST_NOP;
            inst_addr_q <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    assign ibus_req_o   = req_q;
    assign ibus_addr_o  = addr_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_addr_o  = inst_addr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed fetch/jump sequence followed by randomized bus,
// stall, flush and reset traffic, all checked against a transaction-level model.
module tb_if_fetch;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        jump_flag_i;
    logic        jtag_reset_flag_i;
    logic        hold_i;
    logic        hold_pc_o;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    int total = 0;
    int bad   = 0;

    if_fetch #(
        .RESET_ADDR(RESET_ADDR),
        .INST_NOP  (INST_NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_i             (pc_i),
        .jump_flag_i      (jump_flag_i),
        .jtag_reset_flag_i(jtag_reset_flag_i),
        .hold_i           (hold_i),
        .hold_pc_o        (hold_pc_o),
        .ibus_req_o       (ibus_req_o),
        .ibus_addr_o      (ibus_addr_o),
        .ibus_gnt_i       (ibus_gnt_i),
        .ibus_rvalid_i    (ibus_rvalid_i),
        .ibus_rdata_i     (ibus_rdata_i),
        .inst_valid_o     (inst_valid_o),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o)
    );

    always #5 clk = ~clk;

    // Model: one outstanding transaction record plus the decode slot and the PC register.
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_granted;
    bit          m_dead;
    logic [31:0] m_bus_addr;
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_inst_addr;

    bit          s_rst, s_jump, s_jtag, s_hold, s_gnt, s_rvalid;
    logic [31:0] s_rdata, s_target, s_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit model_hold_pc();
        return !(m_pend && !m_granted && s_gnt && !m_dead);
    endfunction

    task automatic model_reset();
        m_pc        = RESET_ADDR;
        m_pend      = 1'b0;
        m_granted   = 1'b0;
        m_dead      = 1'b0;
        m_bus_addr  = RESET_ADDR;
        m_valid     = 1'b0;
        m_inst      = INST_NOP;
        m_inst_addr = RESET_ADDR;
    endtask

    task automatic model_step();
        bit flush, consume, slot_free, deliver, live_grant;
        if (s_rst) begin
            model_reset();
            return;
        end
        flush      = s_jump | s_jtag;
        consume    = m_valid & ~s_hold;
        slot_free  = !m_valid || consume;
        deliver    = 1'b0;
        live_grant = !model_hold_pc();

        if (flush) m_pc = s_target;
        else if (live_grant) m_pc = m_pc + 32'd4;

        if (!m_pend) begin
            if (slot_free && !flush) begin
                m_pend     = 1'b1;
                m_granted  = 1'b0;
                m_dead     = 1'b0;
                m_bus_addr = s_pc & 32'hFFFF_FFFC;
            end
        end else if (!m_granted) begin
            if (flush) m_dead = 1'b1;
            if (s_gnt) m_granted = 1'b1;
        end else begin
            if (s_rvalid) begin
                deliver = !m_dead && !flush;
                m_pend  = 1'b0;
                m_dead  = 1'b0;
            end else if (flush) begin
                m_dead = 1'b1;
            end
        end

        if (flush) begin
            m_valid = 1'b0;
            m_inst  = INST_NOP;
        end else if (deliver) begin
            m_valid     = 1'b1;
            m_inst      = s_rdata;
            m_inst_addr = m_bus_addr;
        end else if (consume) begin
            m_valid = 1'b0;
            m_inst  = INST_NOP;
        end
    endtask

    task automatic checkOutput();
        chk("ibus_req_o",   {31'd0, ibus_req_o},   {31'd0, m_pend && !m_granted});
        chk("ibus_addr_o",  ibus_addr_o,           m_bus_addr);
        chk("inst_valid_o", {31'd0, inst_valid_o}, {31'd0, m_valid});
        chk("inst_o",       inst_o,                m_inst);
        chk("inst_addr_o",  inst_addr_o,           m_inst_addr);
        chk("hold_pc_o",    {31'd0, hold_pc_o},    {31'd0, model_hold_pc()});
    endtask

    // Drives one cycle of inputs at the negedge, checks mid-cycle, then advances the model.
    task automatic applyStimulus(input bit r, input bit j, input bit jt, input bit h,
                                 input bit g, input bit rv, input logic [31:0] rd,
                                 input logic [31:0] tgt, input logic [1:0] low,
                                 output logic hold_seen);
        s_rst = r; s_jump = j; s_jtag = jt; s_hold = h; s_gnt = g; s_rvalid = rv;
        s_rdata = rd; s_target = tgt; s_pc = m_pc | {30'd0, low};
        rst = r; jump_flag_i = j; jtag_reset_flag_i = jt; hold_i = h;
        ibus_gnt_i = g; ibus_rvalid_i = rv; ibus_rdata_i = rd; pc_i = s_pc;
        #1;
        hold_seen = hold_pc_o;
        checkOutput();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        logic hs;
        logic [31:0] zero_w;
        zero_w = 32'd0;
        rst = 1'b1; jump_flag_i = 1'b0; jtag_reset_flag_i = 1'b0; hold_i = 1'b0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0; pc_i = 32'd0;
        model_reset();
        @(negedge clk);

        // Reset values.
        applyStimulus(1, 0, 0, 0, 0, 0, zero_w, zero_w, 2'd0, hs);
        applyStimulus(1, 0, 0, 0, 0, 0, zero_w, zero_w, 2'd0, hs);
        chk("reset req",       {31'd0, ibus_req_o},   32'd0);
        chk("reset addr",      ibus_addr_o,           32'h0000_0000);
        chk("reset valid",     {31'd0, inst_valid_o}, 32'd0);
        chk("reset inst",      inst_o,                32'h0000_0013);
        chk("reset inst_addr", inst_addr_o,           32'h0000_0000);
        chk("reset hold_pc",   {31'd0, hold_pc_o},    32'd1);

        // Zero-wait fetch at PC 0.
        applyStimulus(0, 0, 0, 0, 0, 0, zero_w, zero_w, 2'd0, hs);
        chk("first req",  {31'd0, ibus_req_o}, 32'd1);
        chk("first addr", ibus_addr_o,         32'h0000_0000);
        applyStimulus(0, 0, 0, 0, 1, 0, zero_w, zero_w, 2'd0, hs);
        chk("grant hold_pc low", {31'd0, hs}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h0010_0093, zero_w, 2'd0, hs);
        chk("wait hold_pc high", {31'd0, hs}, 32'd1);
        chk("loaded valid",      {31'd0, inst_valid_o}, 32'd1);
        chk("loaded inst",       inst_o,      32'h0010_0093);
        chk("loaded inst_addr",  inst_addr_o, 32'h0000_0000);

        // Second fetch at PC 4, jump to 0x80 while waiting for the response.
        applyStimulus(0, 0, 0, 0, 0, 0, zero_w, zero_w, 2'd0, hs);
        chk("second addr", ibus_addr_o, 32'h0000_0004);
        applyStimulus(0, 0, 0, 0, 1, 0, zero_w, zero_w, 2'd0, hs);
        applyStimulus(0, 1, 0, 0, 0, 0, zero_w, 32'h0000_0080, 2'd0, hs);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, zero_w, 2'd0, hs);
        chk("dropped valid", {31'd0, inst_valid_o}, 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, zero_w, zero_w, 2'd0, hs);
        chk("target addr", ibus_addr_o, 32'h0000_0080);
        applyStimulus(0, 0, 0, 0, 1, 0, zero_w, zero_w, 2'd0, hs);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678, zero_w, 2'd0, hs);
        chk("target inst",      inst_o,      32'h1234_5678);
        chk("target inst_addr", inst_addr_o, 32'h0000_0080);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r, j, jt, h, g, rv;
            r  = ($urandom_range(0, 199) == 0);
            j  = ($urandom_range(0, 19) == 0);
            jt = ($urandom_range(0, 59) == 0);
            h  = ($urandom_range(0, 9) < 3);
            g  = ($urandom_range(0, 1) == 1);
            rv = ($urandom_range(0, 1) == 1);
            applyStimulus(r, j, jt, h, g, rv, $urandom(),
                          $urandom() & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)), hs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage between the program counter register and the IF/ID decode register. Takes the current PC, issues single-beat reads on the instruction bus with a req/gnt/rvalid handshake, and holds the PC until each read is granted. Presents the returned instruction and its address to decode through a one-entry output slot. Discards in-flight responses on jump or JTAG reset.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0000_0000: reset value of `ibus_addr_o` and `inst_addr_o`; equals the CPU reset address.
- `INST_NOP`, default 32'h0000_0013: instruction driven on `inst_o` when the slot is empty.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `pc_i`  in  32  current PC from the PC register.
- `jump_flag_i`  in  1  jump taken this cycle; flushes the stage.
- `jtag_reset_flag_i`  in  1  JTAG reset; flushes the stage exactly like `jump_flag_i`.
- `hold_i`  in  1  decode stall; slot is not consumed while high.
- `hold_pc_o`  out  1  combinational; high means the PC register must not advance.
- `ibus_req_o`  out  1  registered read request.
- `ibus_addr_o`  out  32  registered read address; word aligned.
- `ibus_gnt_i`  in  1  request accepted this cycle.
- `ibus_rvalid_i`  in  1  read data valid.
- `ibus_rdata_i`  in  32  read data.
- `inst_valid_o`  out  1  output slot holds a valid instruction.
- `inst_o`  out  32  instruction; `INST_NOP` when the slot is empty.
- `inst_addr_o`  out  32  address of `inst_o`.

## Operation
- flush = `jump_flag_i | jtag_reset_flag_i`.
- consume = `inst_valid_o & ~hold_i`.
- slot_free = `~inst_valid_o | consume`.
- FSM states: IDLE, REQ, WAIT. The stage also keeps a `drop` flag. At most one request is outstanding at any time.
- IDLE:
  - If slot_free and no flush: latch `ibus_addr_o <= {pc_i[31:2], 2'b00}`, set `ibus_req_o <= 1`, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `ibus_req_o` and `ibus_addr_o` stay stable until `ibus_gnt_i`, flush or no flush. The request is never withdrawn.
  - On `ibus_gnt_i`: `ibus_req_o <= 0`, go to WAIT.
- WAIT:
  - On `ibus_rvalid_i` with `drop` = 0 and no flush: load the slot with `inst_o <= ibus_rdata_i`, `inst_addr_o <= ibus_addr_o`, `inst_valid_o <= 1`. Go to IDLE.
  - On `ibus_rvalid_i` with `drop` = 1 or with flush: discard the data, clear `drop`, go to IDLE.
  - `ibus_gnt_i`/`ibus_rvalid_i` outside their states are ignored.
- `drop`:
  - Set by flush while in REQ, or while in WAIT without `ibus_rvalid_i`.
  - Cleared when the dropped response is consumed.
- Output slot:
  - Flush clears it: `inst_valid_o <= 0`, `inst_o <= INST_NOP`. This has priority over a load in the same cycle.
  - consume with no load: clear it to `INST_NOP`.
  - When the slot is empty, `inst_addr_o` retains its last value.
  - The slot is always empty or being consumed when a response loads it; no overflow is possible.
- `hold_pc_o = ~(state == REQ & ibus_gnt_i & ~drop)`. The PC advances only on a grant of a live request. A jump still overrides this hold inside the PC register.

## Timing
- Reset values:
  - FSM = IDLE, `drop` = 0.
  - `ibus_req_o` = 0, `ibus_addr_o` = `RESET_ADDR`.
  - `inst_valid_o` = 0, `inst_o` = `INST_NOP`, `inst_addr_o` = `RESET_ADDR`.
  - `hold_pc_o` = 1.
- Reset mid-transaction abandons the request with no drop bookkeeping. The bus must not return a response after reset.
- With zero-wait grant and response, the per-instruction cycle sequence is:
  - cycle 0: IDLE issues the request.
  - cycle 1: REQ receives the grant; PC advances.
  - cycle 2: WAIT receives rvalid.
  - cycle 3: `inst_valid_o` is high.
- Throughput is one instruction per 3 cycles minimum. Each extra gnt or rvalid wait cycle adds 1.
- A flush in cycle N blocks issue in N. The request at the jump target issues from IDLE in N+1, using the updated `pc_i`.

## Test plan
- Reset, then `pc_i`=0, gnt and rvalid each after 0 waits, rdata=32'h0010_0093:
  - `ibus_req_o` high with addr 0.
  - `hold_pc_o` low exactly on the grant cycle.
  - `inst_valid_o`/`inst_o`=32'h0010_0093/`inst_addr_o`=0 one cycle after rvalid.
- Grant delayed 3 cycles with `pc_i`=0x10:
  - `ibus_addr_o` stable at 0x10 and `hold_pc_o` high through all wait cycles.
- `hold_i` high for 4 cycles with the slot full:
  - `inst_o` stable, no new request.
  - A new request issues on the cycle `hold_i` falls.
- `jump_flag_i` pulsed while in WAIT, `pc_i` then 0x80:
  - The pending response is discarded; `inst_valid_o` stays 0.
  - The next request addr is 0x80.
  - The next valid instruction has `inst_addr_o`=0x80.
- `jump_flag_i` in REQ before the grant:
  - The grant keeps `hold_pc_o` high.
  - The response is dropped.
  - A refetch follows at the jump target.
- `rst` asserted in WAIT:
  - All outputs return to their reset values on the next edge.
  - A fetch restarts at `RESET_ADDR`.
